seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds one BCD code per digit and walks the shared active-low segment bus across the digits, one digit at a time. A blanking guard at each digit change prevents ghosting. New display contents are staged and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 1000, clock cycles per digit slot, including blanking (must be > BLANK_CYCLES)
BLANK_CYCLES, 16, cycles per slot with all digits disabled (>= 1)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  reset, synchronous, active-high
load_i  input  1  one-cycle strobe; capture digits_i/dp_i into the staging register
digits_i  input  4*NUM_DIGITS  BCD codes; digit k = bits [4k+3:4k]; digit 0 is the rightmost
dp_i  input  NUM_DIGITS  decimal point per digit, 1 = lit
pending_o  output  1  staged data not yet committed to the display
frame_o  output  1  one-cycle pulse at the start of each frame (digit 0 blank slot begins)
digit_en_o  output  NUM_DIGITS  digit enables, active-low, at most one low at a time
leda, ledb, ledc, ledd, lede, ledf, ledg  output  1 each  segments a..g, active-low (0 = lit)
ledp  output  1  decimal point, active-low

Behaviour:
- Only one clock domain. Reset is synchronous and active-high and overrides all other inputs.
- Reset values:
  - State = BLANK, digit idx = 0, slot counter = 0, pending_o = 0, frame_o = 0.
  - digit_en_o all 1, segments and ledp = 1 (off).
  - Active and staged digit registers = 4'hF (blank code); active and staged dp = 0.
- Outputs decode directly from registered state, idx and counter, with no extra pipeline stage. Cycle n is the n-th rising edge after rst is sampled low, so cycle 0 is the first cycle out of reset.
- FSM:
  - BLANK: digit_en_o all 1, segments and ledp = 1. Lasts BLANK_CYCLES cycles, then moves to DRIVE.
  - DRIVE: digit_en_o[idx] = 0. {leda..ledg} = decode(active[idx]); ledp = ~active_dp[idx]. Lasts CLK_DIV - BLANK_CYCLES cycles, then moves to BLANK with idx+1.
- Counter: the slot counter runs 0..CLK_DIV-1. BLANK covers counts 0..BLANK_CYCLES-1; DRIVE covers the rest. It wraps to 0 at the end of each slot.
- idx wraps from NUM_DIGITS-1 to 0. frame_o = 1 in the first cycle of the idx-0 BLANK slot only, including cycle 0 after reset.
- Decode, {a..g}, active-low:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - 10..15 = 1111111 (blank)
- Load handshake:
  - load_i = 1 copies digits_i/dp_i into the staging register and sets pending_o = 1 on the next cycle.
  - A load while pending_o = 1 overwrites the staged data; last load wins.
- Commit:
  - On the cycle frame_o = 1, if pending_o = 1, staged data is copied to the active registers and pending_o clears.
  - The committed data is therefore visible from that frame's digit-0 DRIVE slot onward.
- Simultaneous load_i and commit in the same cycle: the previously staged data is committed. The new data is captured into staging and pending_o stays 1 for the next frame.
- Reset mid-frame or mid-load: everything returns to reset values and any staged data is discarded. The display is blank until the first commit after a load.

Test Plan:
All scenarios use NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
1. Reset release, no load:
   - Cycles 0-1: digit_en_o = 1111.
   - Cycles 2-7: digit_en_o = 1110, segments = 1111111.
   - frame_o is high at cycles 0, 32, 64.
2. Load digits_i = 16'h4321, dp_i = 4'b0100 at cycle 5:
   - pending_o = 1 from cycle 6 until it clears at cycle 33.
   - Cycles 34-39: digit_en_o = 1110, segments = 1001111 (1), ledp = 1.
   - Slot 2: 0000110 (3), ledp = 0.
   - Slot 3: 1001100 (4).
3. Codes A..F loaded in every digit: segments stay 1111111 in every DRIVE slot; digit_en_o still scans normally.
4. Two loads before a commit (16'h1111 then 16'h9999): only 9 (0000100) is ever displayed.
5. Load asserted exactly on a frame_o cycle (staged 16'h2222, new 16'h5555):
   - 2222 is displayed in this frame; pending_o stays 1.
   - 5555 is committed at the next frame_o.
6. rst asserted mid-DRIVE of digit 2, held 1 cycle:
   - Next cycle: all outputs off, pending_o = 0.
   - Restart matches scenario 1, and the display stays blank.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Digits are staged on load_i and committed only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic                    pending_o,
    output logic                    frame_o,
    output logic [NUM_DIGITS-1:0]   digit_en_o,
    output logic                    leda,
    output logic                    ledb,
    output logic                    ledc,
    output logic                    ledd,
    output logic                    lede,
    output logic                    ledf,
    output logic                    ledg,
    output logic                    ledp
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] staged_q, staged_d;
    logic [NUM_DIGITS-1:0]   staged_dp_q, staged_dp_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;

    logic       frame_w;
    logic       commit_w;
    logic [3:0] cur_code;
    logic       cur_dp;
    logic [6:0] seg_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            staged_q    <= '1;
            staged_dp_q <= '0;
            active_q    <= '1;
            active_dp_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pending_q   <= pending_d;
            staged_q    <= staged_d;
            staged_dp_q <= staged_dp_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
        end
    end

    // Slot timing: counts 0..BLANK_CYCLES-1 are blanking, the rest drive the digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = (cnt_q == SLOT_LAST) ? '0 : cnt_q + 1'b1;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = ST_BLANK;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    assign frame_w  = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
    assign commit_w = frame_w && pending_q;

    // load_i is a fire-and-forget strobe with no back-pressure: the last load
    // before a frame start wins, and a load coinciding with a commit is kept
    // staged for the following frame.
    always_comb begin
        pending_d   = pending_q;
        staged_d    = staged_q;
        staged_dp_d = staged_dp_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        if (commit_w) begin
            active_d    = staged_q;
            active_dp_d = staged_dp_q;
            pending_d   = 1'b0;
        end
        if (load_i) begin
            staged_d    = digits_i;
            staged_dp_d = dp_i;
            pending_d   = 1'b1;
        end
    end

    assign cur_code = active_q[{idx_q, 2'b00} +: 4];
    assign cur_dp   = active_dp_q[idx_q];

    always_comb begin
        digit_en_o = '1;
        seg_w      = 7'b1111111;
        ledp       = 1'b1;
        if (state_q == ST_DRIVE) begin
            digit_en_o[idx_q] = 1'b0;
            seg_w             = seg_decode(cur_code);
            ledp              = ~cur_dp;
        end
    end

    assign {leda, ledb, ledc, ledd, lede, ledf, ledg} = seg_w;
    assign frame_o   = frame_w;
    assign pending_o = pending_q;

endmodule
